// File: rtl/coreir_stream_pkg.sv
// coreir_stream_pkg: shared helpers and FSM state type for the streaming width converters.
package coreir_stream_pkg;

    typedef enum logic {EMPTY, BUSY} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Index width for a counter over n lanes; never narrower than one bit.
    function automatic int idx_width(input int n);
        return clog2(n) > 1 ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slice_lane_mux.sv
// slice_lane_mux: selects lane idx (OUT_WIDTH bits) out of an IN_WIDTH word.
module slice_lane_mux
    import coreir_stream_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 4,
    localparam int N  = IN_WIDTH / OUT_WIDTH,
    localparam int IW = idx_width(N)
) (
    input  logic [IN_WIDTH-1:0]  word,
    input  logic [IW-1:0]        idx,
    output logic [OUT_WIDTH-1:0] slice
);

    always_comb begin
        slice = '0;
        for (int k = 0; k < N; k++)
            if (idx == IW'(k)) slice = word[k*OUT_WIDTH +: OUT_WIDTH];
    end

endmodule

// File: rtl/slice_unpacker.sv
// slice_unpacker: splits each accepted IN_WIDTH word into IN_WIDTH/OUT_WIDTH slices, LSB slice first.
module slice_unpacker
    import coreir_stream_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam int N  = IN_WIDTH / OUT_WIDTH;
    localparam int IW = idx_width(N);

    state_t               state;
    logic [IW-1:0]        idx;
    logic [IN_WIDTH-1:0]  word_q;
    logic [OUT_WIDTH-1:0] lane;

    slice_lane_mux #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_mux (
        .word (word_q),
        .idx  (idx),
        .slice(lane)
    );

    assign out_valid = state == BUSY;
    assign out_data  = out_valid ? lane : '0;
    assign out_last  = out_valid && idx == IW'(N - 1);
    // Reloading on the final slice keeps back-to-back words bubble-free.
    assign in_ready  = state == EMPTY || (out_ready && out_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            idx    <= '0;
            word_q <= '0;
        end else if (state == EMPTY) begin
            if (in_valid) begin
                word_q <= in_data;
                idx    <= '0;
                state  <= BUSY;
            end
        end else if (out_ready) begin
            if (!out_last) begin
                idx <= idx + 1'b1;
            end else if (in_valid) begin
                word_q <= in_data;
                idx    <= '0;
            end else begin
                idx   <= '0;
                state <= EMPTY;
            end
        end
    end

endmodule

// File: doc/slice_unpacker.md
Name: slice_unpacker

Overview:
- Streaming width down-converter; the inverse of concatenation.
- Accepts one IN_WIDTH word over a valid/ready handshake and emits it as IN_WIDTH/OUT_WIDTH consecutive OUT_WIDTH slices, least-significant slice first.
- Slice k equals in[(k+1)*OUT_WIDTH-1 : k*OUT_WIDTH], so the lowest-index operand of a concat is emitted first.
- Sits between wide datapath producers and narrow serial consumers in generated netlists.

Parameters:
- IN_WIDTH, 16, input word width; must be a nonzero multiple of OUT_WIDTH.
- OUT_WIDTH, 4, output slice width, >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset.
- in_data  input  IN_WIDTH  wide word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  OUT_WIDTH  current slice.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer takes out_data this cycle.
- out_last  output  1  current slice is the final (most-significant) slice of the word.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Constants: N = IN_WIDTH/OUT_WIDTH; IW = max(1, clog2(N)).
- State: buf (IN_WIDTH), idx (IW bits), and a two-state FSM, EMPTY or BUSY.
- Reset: on rst high at a clock edge, state = EMPTY, idx = 0, buf = 0.
  - Outputs after reset: out_valid = 0, out_last = 0, out_data = 0, in_ready = 1.
  - A reset mid-word discards the remaining slices; no partial output follows.
- Handshakes: a transfer occurs when valid && ready at a rising edge.
  - out_valid, once high, stays high with stable out_data until out_ready.
  - in_valid/in_data are not sampled unless in_ready is high.
- Combinational outputs:
  - out_valid = (state == BUSY).
  - out_data = buf[idx*OUT_WIDTH +: OUT_WIDTH] when BUSY, else 0.
  - out_last = BUSY && (idx == N-1).
  - in_ready = (state == EMPTY) || (out_ready && out_last). This is a combinational path out_ready -> in_ready, which is intentional.
- EMPTY state: on input transfer, buf <= in_data, idx <= 0, go to BUSY.
- BUSY state, output transfer with idx < N-1: idx <= idx+1.
- BUSY state, output transfer with idx == N-1:
  - If an input transfer also occurs the same cycle: buf <= in_data, idx <= 0, stay BUSY. This gives full throughput with no bubble.
  - Otherwise: go to EMPTY, idx <= 0.
- BUSY state, no output transfer: hold all state.
- Latency: first slice appears the cycle after input acceptance.
- Throughput: one word per N cycles when out_ready is held high.
- N == 1: acts as a one-entry pipeline register; out_last is high whenever out_valid is high. Back-to-back transfers run at 1 word/cycle.
- idx never exceeds N-1; there is no wrap past N-1 other than the reload to 0.

Decomposition:
- Shared package (coreir_stream_pkg):
  - function clog2;
  - localparams N and IW derived per instance;
  - FSM state enum {EMPTY, BUSY}.
- One sub-module, slice_lane_mux (parameters IN_WIDTH, OUT_WIDTH; inputs word and idx; output slice). It is purely combinational lane selection, reusable by a future packer.
- The FSM and counter stay in slice_unpacker.

Test Plan:
- Reset then idle: rst high 2 cycles, then low -> out_valid=0, in_ready=1, out_data=0 while in_valid=0.
- Basic unpack: in_data=16'hABCD accepted, out_ready=1 -> out_data D,C,B,A on 4 consecutive cycles; out_last high only on A; in_ready=0 on the first 3, 1 on the 4th.
- Back-to-back: words 16'h1234 and 16'h5678 with in_valid held, out_ready=1 -> slices 4,3,2,1,8,7,6,5 on 8 consecutive cycles with no bubble.
- Backpressure: during 16'hABCD, drop out_ready for 3 cycles while slice C is shown -> out_data stays C and out_valid stays 1; sequence resumes with B, then A.
- Reset mid-word: assert rst after slice D of 16'hABCD -> next cycle out_valid=0; the next word 16'h0F0F yields F,0,F,0 cleanly.
- N==1 config (IN_WIDTH=OUT_WIDTH=8): 8'h5A then 8'hC3 streamed -> out_data 5A, C3 on consecutive cycles with out_last=1 on each.
